// File: rtl/wb_arbiter_pkg.sv
// Shared types for the 2:1 Wishbone arbiter.
// Optional bus timeout: WB_ARBITER_TIMEOUT_EN.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_e;

  localparam logic GNT_M0 = 1'b0;
  localparam logic GNT_M1 = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic arb_state_e grant_state(
    input logic idx
  );
    return idx ? ST_GRANT1 : ST_GRANT0;
  endfunction

endpackage

// File: rtl/wb_arbiter_2to1_rr_pick.sv
// Two-way round-robin picker.
// A tie goes to the master that was not granted last.
module wb_rr_pick
  import wb_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       grant_idx_o
);

  // pick a single requester, or alternate on a tie
  always_comb begin
    valid_o     = |req_i;
    grant_idx_o = GNT_M0;
    unique case (req_i)
      2'b01:   grant_idx_o = GNT_M0;
      2'b10:   grant_idx_o = GNT_M1;
      2'b11:   grant_idx_o = ~last_grant_i;
      default: grant_idx_o = GNT_M0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// 2:1 Wishbone arbiter, grant held for a whole CYC span.
// Optional bus timeout: WB_ARBITER_TIMEOUT_EN.
module wb_arbiter_2to1
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [7:0]            m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [7:0]            m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [7:0]            m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [7:0]            m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [7:0]            s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [7:0]            s_dat_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] req;
  logic       pick_valid;
  logic       pick_idx;
  logic       owner_cyc;
  logic       timeout;

  assign req       = {m1_cyc_i, m0_cyc_i};
  assign owner_cyc = last_q ? m1_cyc_i : m0_cyc_i;

  wb_rr_pick u_pick (
    .req_i        (req),
    .last_grant_i (last_q),
    .valid_o      (pick_valid),
    .grant_idx_o  (pick_idx)
  );

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;
  logic       granted;
  logic       owner_stb;
  logic       s_rsp;

  assign granted   = (state_q == ST_GRANT0) ||
                     (state_q == ST_GRANT1);
  assign owner_stb = last_q ? m1_stb_i : m0_stb_i;
  assign s_rsp     = s_ack_i | s_err_i | s_rty_i;
  assign timeout   = granted && owner_cyc &&
                     (cnt_q == TO_LIMIT);

  // count stalled strobe cycles of the current owner
  always_comb begin
    cnt_d = '0;
    if (granted && owner_cyc && !timeout) begin
      if (s_rsp)
        cnt_d = '0;
      else if (owner_stb)
        cnt_d = cnt_q + 8'd1;
      else
        cnt_d = cnt_q;
    end
  end

  // stall counter register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // state and last-grant registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= GNT_M1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // next state: hold the grant until the owner drops CYC
  always_comb begin
    logic rearb;
    rearb   = 1'b0;
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: rearb = 1'b1;
      ST_GRANT0,
      ST_GRANT1: begin
        if (!owner_cyc)
          rearb = 1'b1;
        else if (timeout)
          state_d = ST_ABORT;
      end
      ST_ABORT: begin
        if (!owner_cyc)
          rearb = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rearb) begin
      if (pick_valid) begin
        state_d = grant_state(pick_idx);
        last_d  = pick_idx;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // outputs: mux the owner onto the slave, route responses back
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      ST_GRANT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        m0_rty_o = s_rty_i;
        m0_dat_o = s_dat_i;
      end
      ST_GRANT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        m1_rty_o = s_rty_i;
        m1_dat_o = s_dat_i;
      end
      default: ;
    endcase
    if (timeout) begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_ack_o = 1'b0;
      m1_rty_o = 1'b0;
      m0_err_o = (last_q == GNT_M0);
      m1_err_o = (last_q == GNT_M1);
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for the 2:1 Wishbone arbiter.
// Timeout sequence runs when WB_ARBITER_TIMEOUT_EN is set.
module tb_wb_arbiter_2to1;

  localparam logic [23:0] A0 = 24'h000100;
  localparam logic [23:0] A1 = 24'h800010;
`ifdef WB_ARBITER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m0_cyc, m0_stb, m0_ack, m0_err, m0_rty;
  logic m1_cyc, m1_stb, m1_ack, m1_err, m1_rty;
  logic [7:0] m0_do, m1_do;
  logic s_cyc, s_stb, s_we;
  logic [23:0] s_adr;
  logic [7:0] s_do;
  logic s_ack, s_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(
    .ADDR_WIDTH     (24),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (1'b1),
    .m0_adr_i (A0),
    .m0_dat_i (8'hA5),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m0_rty_o (m0_rty),
    .m0_dat_o (m0_do),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (1'b0),
    .m1_adr_i (A1),
    .m1_dat_i (8'h5A),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .m1_rty_o (m1_rty),
    .m1_dat_o (m1_do),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_do),
    .s_ack_i  (s_ack),
    .s_err_i  (s_err),
    .s_rty_i  (1'b0),
    .s_dat_i  (8'h41)
  );

  typedef struct {
    bit c0, s0, c1, s1, ack, err;
    int g;
    bit e_cyc, e_stb, e_ack0, e_ack1, e_err1;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input bit c0, s0, c1, s1, ack, err,
    input int g,
    input bit e_cyc, e_stb, e_ack0, e_ack1, e_err1
  );
    vec_t v;
    v = '{c0, s0, c1, s1, ack, err, g,
          e_cyc, e_stb, e_ack0, e_ack1, e_err1};
    tbl.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit c0, s0, c1, s1);
    m0_cyc = c0;
    m0_stb = s0;
    m1_cyc = c1;
    m1_stb = s1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 1, 1);
    s_ack = 1'b1;
    s_err = 1'b0;

    // idle/no-grant (0), grant m0 (1), grant m1 (2)
    add(0,0,0,0,0,0, 0, 0,0,0,0,0);
    add(0,0,1,1,0,0, 0, 0,0,0,0,0);
    add(0,0,1,1,0,0, 2, 1,1,0,0,0);
    add(0,0,1,1,0,1, 2, 1,1,0,0,1);
    add(0,0,1,1,1,0, 2, 1,1,0,1,0);
    add(0,0,0,0,0,0, 2, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0, 0,0,0,0,0);
    add(1,1,1,1,0,0, 0, 0,0,0,0,0);
    add(1,1,1,1,1,0, 1, 1,1,1,0,0);
    add(0,0,1,1,0,0, 1, 0,0,0,0,0);
    add(0,0,1,1,1,0, 2, 1,1,0,1,0);
    add(1,1,0,0,0,0, 2, 0,0,0,0,0);
    add(1,1,1,1,1,0, 1, 1,1,1,0,0);
    add(0,0,1,1,0,0, 1, 0,0,0,0,0);
    add(1,1,1,1,1,0, 2, 1,1,0,1,0);
    add(1,1,0,0,0,0, 2, 0,0,0,0,0);
    add(1,1,1,1,1,0, 1, 1,1,1,0,0);
    add(0,0,1,1,0,0, 1, 0,0,0,0,0);
    add(0,0,1,1,1,0, 2, 1,1,0,1,0);
    add(0,0,0,0,0,0, 2, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0, 0,0,0,0,0);
    add(1,1,1,1,0,0, 0, 0,0,0,0,0);
    for (int i = 0; i < 4; i++)
      add(1,1,1,1,1,0, 1, 1,1,1,0,0);
    add(0,0,1,1,0,0, 1, 0,0,0,0,0);
    add(0,0,1,1,1,0, 2, 1,1,0,1,0);
    add(0,0,0,0,0,0, 2, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0, 0,0,0,0,0);

    // held in reset with a request and a stray ack
    tick();
    tick();
    #3;
    chk("rst_cyc", 32'(s_cyc), 0);
    chk("rst_adr", 32'(s_adr), 0);
    chk("rst_ack1", 32'(m1_ack), 0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    s_ack = 1'b0;

    foreach (tbl[i]) begin
      logic [23:0] ea;
      logic        ew;
      logic [7:0]  eso, ed0, ed1;
      tick();
      drive(tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1);
      s_ack = tbl[i].ack;
      s_err = tbl[i].err;
      #3;
      ea = '0; ew = 0; eso = '0; ed0 = '0; ed1 = '0;
      if (tbl[i].g == 1) begin
        ea = A0; ew = 1; eso = 8'hA5; ed0 = 8'h41;
      end else if (tbl[i].g == 2) begin
        ea = A1; eso = 8'h5A; ed1 = 8'h41;
      end
      chk($sformatf("v%0d_cyc", i), 32'(s_cyc), 32'(tbl[i].e_cyc));
      chk($sformatf("v%0d_stb", i), 32'(s_stb), 32'(tbl[i].e_stb));
      chk($sformatf("v%0d_we", i), 32'(s_we), 32'(ew));
      chk($sformatf("v%0d_adr", i), 32'(s_adr), 32'(ea));
      chk($sformatf("v%0d_sdo", i), 32'(s_do), 32'(eso));
      chk($sformatf("v%0d_ack0", i), 32'(m0_ack), 32'(tbl[i].e_ack0));
      chk($sformatf("v%0d_ack1", i), 32'(m1_ack), 32'(tbl[i].e_ack1));
      chk($sformatf("v%0d_err1", i), 32'(m1_err), 32'(tbl[i].e_err1));
      chk($sformatf("v%0d_err0", i), 32'(m0_err), 0);
      chk($sformatf("v%0d_dat0", i), 32'(m0_do), 32'(ed0));
      chk($sformatf("v%0d_dat1", i), 32'(m1_do), 32'(ed1));
    end

    // reset while m1 holds the grant with STB high
    tick();
    drive(0, 0, 1, 1);
    s_ack = 1'b0;
    s_err = 1'b0;
    tick();
    #3;
    chk("mid_pre_cyc", 32'(s_cyc), 1);
    chk("mid_pre_adr", 32'(s_adr), 32'(A1));
    tick();
    rst = 1'b1;
    s_ack = 1'b1;
    tick();
    #3;
    chk("mid_rst_cyc", 32'(s_cyc), 0);
    chk("mid_rst_ack1", 32'(m1_ack), 0);
    tick();
    rst = 1'b0;
    s_ack = 1'b0;
    drive(1, 1, 1, 1);
    #3;
    chk("mid_idle_cyc", 32'(s_cyc), 0);
    tick();
    #3;
    chk("mid_tie_adr", 32'(s_adr), 32'(A0));
    chk("mid_tie_cyc", 32'(s_cyc), 1);
    tick();
    drive(0, 0, 0, 0);
    tick();

`ifdef WB_ARBITER_TIMEOUT_EN
    // stalled slave: m1 is aborted, pending m0 then wins
    tick();
    drive(0, 0, 1, 1);
    #3;
    chk("to_idle_cyc", 32'(s_cyc), 0);
    for (int k = 0; k <= TO; k++) begin
      tick();
      if (k == TO) drive(1, 1, 1, 1);
      #3;
      chk($sformatf("to_err1_%0d", k), 32'(m1_err), 32'(k == TO));
      chk($sformatf("to_cyc_%0d", k), 32'(s_cyc), 32'(k < TO));
      chk($sformatf("to_err0_%0d", k), 32'(m0_err), 0);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      #3;
      chk($sformatf("ab_cyc_%0d", k), 32'(s_cyc), 0);
      chk($sformatf("ab_err1_%0d", k), 32'(m1_err), 0);
    end
    tick();
    drive(1, 1, 0, 0);
    #3;
    chk("ab_rel_cyc", 32'(s_cyc), 0);
    tick();
    #3;
    chk("ab_g0_cyc", 32'(s_cyc), 1);
    chk("ab_g0_adr", 32'(s_adr), 32'(A0));
    tick();
    drive(0, 0, 0, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
